adc_ch_averager: RTL and testbench

//  Downstream stage of the SAR ADC sequencer. Consumes each conversion result (eoc edge + data + channel).

---
 rtl/adc_ch_averager_pkg.sv | 24 ++
 rtl/adc_ch_averager_acc.sv | 59 +++++
 rtl/adc_ch_averager.sv | 175 +++++++++++++++++
 tb/tb_adc_ch_averager.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ch_averager_pkg.sv
// Shared constants, output FSM encoding and helpers for the per-channel ADC averager.
// Every averager source file imports this package.
package adc_ch_averager_pkg;

  localparam int ADC_DW       = 10;
  localparam int ADC_CH_W     = 3;
  localparam int ADC_MAX_LOG2 = 4;
  localparam int ADC_LOG2_W   = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Requested depths beyond the accumulator's headroom saturate at max_log2.
  function automatic logic [ADC_LOG2_W-1:0] clamp_log2(input logic [ADC_LOG2_W-1:0] req,
                                                       input int max_log2);
    if (int'(req) > max_log2) begin
      return ADC_LOG2_W'(max_log2);
    end
    return req;
  endfunction

endpackage

// File: rtl/adc_ch_averager_acc.sv
// One channel's running sum and sample counter. The module signals done on the last sample
// of a window. It produces the truncated mean and restarts in the same cycle.
module adc_ch_acc
  import adc_ch_averager_pkg::*;
#(
  parameter int DW       = ADC_DW,
  parameter int MAX_LOG2 = ADC_MAX_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  add_i,
  input  logic [DW-1:0]         data_i,
  input  logic [ADC_LOG2_W-1:0] n_i,
  output logic                  done_o,
  output logic [DW-1:0]         result_o
);

  localparam int ACC_W = DW + MAX_LOG2;
  localparam int CNT_W = MAX_LOG2;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt_last;

  assign sum      = acc_q + ACC_W'(data_i);
  assign cnt_last = CNT_W'((32'd1 << n_i) - 32'd1);
  assign done_o   = add_i && (cnt_q == cnt_last);
  assign result_o = DW'(sum >> n_i);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add_i) begin
      if (done_o) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_ch_averager.sv
// Per-channel ADC result averager. Stage 1 captures the conversion result.
// Stage 2 accumulates the sample and, when a window completes, loads a valid/ready output
// register with window flags and sticky alarm/overrun status.
module adc_ch_averager
  import adc_ch_averager_pkg::*;
#(
  parameter int DW       = ADC_DW,
  parameter int CH_W     = ADC_CH_W,
  parameter int MAX_LOG2 = ADC_MAX_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADC_LOG2_W-1:0] avg_log2,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_data,
  input  logic [CH_W-1:0]       in_ch,
  input  logic [DW-1:0]         win_lo,
  input  logic [DW-1:0]         win_hi,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic                  out_below,
  output logic                  out_above,
  output logic [2**CH_W-1:0]    win_alarm,
  input  logic [2**CH_W-1:0]    alarm_clr,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int NCH = 2 ** CH_W;

  logic                  s1_valid_q, s1_valid_d;
  logic [DW-1:0]         s1_data_q, s1_data_d;
  logic [CH_W-1:0]       s1_ch_q, s1_ch_d;
  logic [ADC_LOG2_W-1:0] n_eff;

  logic [NCH-1:0]        ch_done;
  logic [DW-1:0]         ch_result [NCH];

  logic                  res_valid;
  logic [DW-1:0]         res_data;
  logic                  res_below, res_above;

  out_state_e            state_q, state_d;
  logic                  load, drop;
  logic [DW-1:0]         out_data_q, out_data_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic                  out_below_q, out_below_d;
  logic                  out_above_q, out_above_d;

  logic [NCH-1:0]        alarm_q, alarm_d, alarm_set;
  logic                  overrun_q, overrun_d;

  assign n_eff = clamp_log2(avg_log2, MAX_LOG2);

  // Stage 1: capture a result only while enabled. Dropping en also discards a staged sample.
  always_comb begin
    s1_valid_d = in_valid && en;
    s1_data_d  = s1_data_q;
    s1_ch_d    = s1_ch_q;
    if (in_valid && en) begin
      s1_data_d = in_data;
      s1_ch_d   = in_ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_ch_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_ch_q    <= s1_ch_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    adc_ch_acc #(
      .DW       (DW),
      .MAX_LOG2 (MAX_LOG2)
    ) u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (!en),
      .add_i    (s1_valid_q && en && (s1_ch_q == CH_W'(i))),
      .data_i   (s1_data_q),
      .n_i      (n_eff),
      .done_o   (ch_done[i]),
      .result_o (ch_result[i])
    );
  end

  // Only the staged channel can complete a window, so its lane supplies the result.
  assign res_valid = ch_done[s1_ch_q];
  assign res_data  = ch_result[s1_ch_q];
  assign res_below = res_data < win_lo;
  assign res_above = res_data > win_hi;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (res_valid) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          load    = res_valid;
          state_d = res_valid ? FULL : EMPTY;
        end else begin
          drop = res_valid;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_below_d = out_below_q;
    out_above_d = out_above_q;
    alarm_set   = '0;
    if (load) begin
      out_data_d  = res_data;
      out_ch_d    = s1_ch_q;
      out_below_d = res_below;
      out_above_d = res_above;
      if (res_below || res_above) begin
        alarm_set = NCH'(1) << s1_ch_q;
      end
    end
  end

  // A new event wins over a clear that arrives in the same cycle.
  assign alarm_d   = (alarm_q & ~alarm_clr) | alarm_set;
  assign overrun_d = (overrun_q & ~overrun_clr) | drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_below_q <= 1'b0;
      out_above_q <= 1'b0;
      alarm_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_below_q <= out_below_d;
      out_above_q <= out_above_d;
      alarm_q     <= alarm_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_below = out_below_q;
  assign out_above = out_above_q;
  assign win_alarm = alarm_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_ch_averager.sv
// Directed and randomized bench for adc_ch_averager.
// A reference model checks the DUT each cycle. The model keeps per-channel sample sums
// and applies the output buffer rules.
module tb_adc_ch_averager;

  localparam int DW  = 10;
  localparam int CHW = 3;
  localparam int NCH = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [2:0]      avg_log2;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic [CHW-1:0]  in_ch;
  logic [DW-1:0]   win_lo, win_hi;
  logic            out_valid, out_ready;
  logic [DW-1:0]   out_data;
  logic [CHW-1:0]  out_ch;
  logic            out_below, out_above;
  logic [NCH-1:0]  win_alarm, alarm_clr;
  logic            overrun, overrun_clr;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: raw sample sums per channel plus an abstract one-entry output buffer.
  int             mSum [NCH];
  int             mCnt [NCH];
  bit             arrV;
  int             arrD, arrCh;
  bit             mFull, mBelow, mAbove, mOverrun;
  int             mData, mCh;
  logic [NCH-1:0] mAlarm;

  int dutOutCount;
  int lastData, lastCh;

  always #5 clk = ~clk;

  adc_ch_averager dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .avg_log2    (avg_log2),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ch       (in_ch),
    .win_lo      (win_lo),
    .win_hi      (win_hi),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_below   (out_below),
    .out_above   (out_above),
    .win_alarm   (win_alarm),
    .alarm_clr   (alarm_clr),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) begin
      mSum[c] = 0;
      mCnt[c] = 0;
    end
    arrV = 0; arrD = 0; arrCh = 0;
    mFull = 0; mBelow = 0; mAbove = 0; mOverrun = 0;
    mData = 0; mCh = 0; mAlarm = '0;
  endtask

  task automatic checkOutput();
    check("out_valid", out_valid, mFull);
    if (mFull) begin
      check("out_data", out_data, mData);
      check("out_ch", out_ch, mCh);
      check("out_below", out_below, mBelow);
      check("out_above", out_above, mAbove);
    end
    check("win_alarm", win_alarm, mAlarm);
    check("overrun", overrun, mOverrun);
    if (out_valid === 1'b1) begin
      dutOutCount++;
      lastData = out_data;
      lastCh   = out_ch;
    end
  endtask

  // Advance one clock with the currently driven inputs, update the model, then check.
  task automatic applyStimulus();
    int n;
    bit a, doLoad, setOvr;
    logic [NCH-1:0] setAlarm;
    n = (avg_log2 > 3'd4) ? 4 : int'(avg_log2);
    @(posedge clk);
    a        = arrV && en;
    doLoad   = a && (!mFull || out_ready);
    setOvr   = 0;
    setAlarm = '0;
    if (doLoad) begin
      mFull  = 1;
      mData  = arrD;
      mCh    = arrCh;
      mBelow = arrD < int'(win_lo);
      mAbove = arrD > int'(win_hi);
      if (mBelow || mAbove) setAlarm[arrCh] = 1'b1;
    end else if (mFull && out_ready) begin
      mFull = 0;
    end else if (mFull && a) begin
      setOvr = 1;
    end
    mAlarm   = (mAlarm & ~alarm_clr) | setAlarm;
    mOverrun = (mOverrun && !overrun_clr) || setOvr;
    arrV = 0;
    if (!en) begin
      for (int c = 0; c < NCH; c++) begin
        mSum[c] = 0;
        mCnt[c] = 0;
      end
    end else if (in_valid) begin
      mSum[in_ch] += int'(in_data);
      mCnt[in_ch]++;
      if (mCnt[in_ch] == (1 << n)) begin
        arrV  = 1;
        arrD  = mSum[in_ch] >> n;
        arrCh = int'(in_ch);
        mSum[in_ch] = 0;
        mCnt[in_ch] = 0;
      end
    end
    #1;
    checkOutput();
  endtask

  task automatic sendSample(input int ch, input int d);
    in_valid = 1'b1;
    in_ch    = CHW'(ch);
    in_data  = DW'(d);
    applyStimulus();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) applyStimulus();
  endtask

  task automatic setDepth(input int d);
    en       = 1'b0;
    avg_log2 = 3'(d);
    applyStimulus();
    en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; avg_log2 = '0; in_valid = 1'b0; in_data = '0; in_ch = '0;
    win_lo = '0; win_hi = '1; out_ready = 1'b1; alarm_clr = '0; overrun_clr = 1'b0;
    modelReset();
    dutOutCount = 0; lastData = 0; lastCh = 0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_win_alarm", win_alarm, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: reset in the middle of a window, then a clean 16-sample window on ch2
    setDepth(4);
    for (int i = 0; i < 5; i++) sendSample(2, 'h3FF);
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    check("t1_rst_valid", out_valid, 0);
    check("t1_rst_alarm", win_alarm, 0);
    check("t1_rst_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dutOutCount = 0;
    for (int i = 0; i < 16; i++) sendSample(2, 'h100);
    idle(3);
    check("t1_count", dutOutCount, 1);
    check("t1_data", lastData, 'h100);
    check("t1_ch", lastCh, 2);

    // 2: depth 4, ch5 gets 1,2,3,6 -> 3, two cycles after the last sample
    setDepth(2);
    dutOutCount = 0;
    sendSample(5, 1); sendSample(5, 2); sendSample(5, 3);
    sendSample(5, 6);
    check("t2_early", out_valid, 0);
    applyStimulus();
    check("t2_valid", out_valid, 1);
    check("t2_data", out_data, 3);
    idle(2);
    check("t2_count", dutOutCount, 1);

    // 3: depth 2, ch0 and ch7 interleaved every cycle
    setDepth(1);
    dutOutCount = 0;
    for (int i = 0; i < 8; i++) sendSample((i % 2 == 0) ? 0 : 7, (i % 2 == 0) ? 'h3FF : 0);
    idle(2);
    check("t3_count", dutOutCount, 4);

    // 4: backpressure with pass-through depth
    setDepth(0);
    out_ready = 1'b0;
    sendSample(1, 'h010);
    sendSample(1, 'h020);
    idle(2);
    check("t4_hold_data", out_data, 'h010);
    check("t4_overrun", overrun, 1);
    sendSample(1, 'h030);
    overrun_clr = 1'b1;
    applyStimulus();
    check("t4_set_wins", overrun, 1);
    applyStimulus();
    overrun_clr = 1'b0;
    check("t4_cleared", overrun, 0);
    out_ready = 1'b1;
    idle(2);

    // 5: window comparator on ch3
    win_lo = 'h080; win_hi = 'h300;
    sendSample(3, 'h07F); applyStimulus();
    check("t5_below0", out_below, 1); check("t5_above0", out_above, 0);
    sendSample(3, 'h200); applyStimulus();
    check("t5_below1", out_below, 0); check("t5_above1", out_above, 0);
    sendSample(3, 'h301); applyStimulus();
    check("t5_below2", out_below, 0); check("t5_above2", out_above, 1);
    check("t5_alarm3", win_alarm[3], 1);
    alarm_clr = 8'h08;
    applyStimulus();
    alarm_clr = '0;
    check("t5_alarm3_clr", win_alarm[3], 0);
    win_lo = '0; win_hi = '1;

    // 6: dropping en discards a partial window
    setDepth(2);
    dutOutCount = 0;
    for (int i = 0; i < 3; i++) sendSample(1, 'h200);
    idle(2);
    en = 1'b0; applyStimulus(); en = 1'b1;
    for (int i = 0; i < 4; i++) sendSample(1, 8);
    idle(3);
    check("t6_count", dutOutCount, 1);
    check("t6_data", lastData, 8);

    // Randomized traffic, depth and window, with random backpressure and clears
    for (int blk = 0; blk < 8; blk++) begin
      win_lo = DW'($urandom_range(0, 1023));
      win_hi = DW'($urandom_range(0, 1023));
      setDepth($urandom_range(0, 7));
      for (int i = 0; i < 60; i++) begin
        in_valid    = ($urandom_range(0, 99) < 70);
        in_ch       = CHW'($urandom_range(0, NCH - 1));
        in_data     = DW'($urandom_range(0, 1023));
        out_ready   = ($urandom_range(0, 99) < 75);
        alarm_clr   = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '0;
        overrun_clr = ($urandom_range(0, 9) == 0);
        applyStimulus();
      end
      in_valid = 1'b0; alarm_clr = '0; overrun_clr = 1'b0; out_ready = 1'b1;
      idle(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
